// File: rtl/q3c_pkg.sv
// Shared state codes, controller states and transition/output functions for
// the Q3c 5-state FSM and its serializing driver.
package q3c_pkg;

  localparam logic [2:0] ST_A = 3'd0;
  localparam logic [2:0] ST_B = 3'd1;
  localparam logic [2:0] ST_C = 3'd2;
  localparam logic [2:0] ST_D = 3'd3;
  localparam logic [2:0] ST_E = 3'd4;

  typedef enum logic [1:0] {
    CTL_IDLE  = 2'd0,
    CTL_SHIFT = 2'd1,
    CTL_DONE  = 2'd2
  } ctl_t;

  // Codes 5..7 are unreachable in normal operation; they recover to A.
  function automatic logic [2:0] next_state(input logic [2:0] y, input logic x);
    case (y)
      ST_A:    next_state = x ? ST_B : ST_A;
      ST_B:    next_state = x ? ST_E : ST_B;
      ST_C:    next_state = x ? ST_B : ST_C;
      ST_D:    next_state = x ? ST_C : ST_B;
      ST_E:    next_state = x ? ST_E : ST_D;
      default: next_state = ST_A;
    endcase
  endfunction

  function automatic logic z_of(input logic [2:0] y);
    return (y == ST_D) || (y == ST_E);
  endfunction

endpackage

// File: rtl/q3c_piso_shifter.sv
// Parallel-in serial-out shifter: loads a word left-aligned so bit [len-1]
// appears first on bit_out, and flags the final bit of the word.
module q3c_piso_shifter #(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          load,
  input  logic [W-1:0]  data,
  input  logic [CW-1:0] len,
  input  logic          shift_en,
  output logic          bit_out,
  output logic          last
);

  logic [W-1:0]  sreg;
  logic [CW-1:0] remaining;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sreg      <= '0;
      remaining <= '0;
    end else if (load) begin
      // Left-align so the first bit to send sits in the MSB.
      sreg      <= data << (CW'(W) - len);
      remaining <= len;
    end else if (shift_en) begin
      sreg      <= sreg << 1;
      remaining <= remaining - CW'(1);
    end
  end

  assign bit_out = sreg[W-1];
  assign last    = (remaining == CW'(1));

endmodule

// File: rtl/q3c_x_stream_driver.sv
// Serializes handshaked words MSB-first onto x, advances the Q3c FSM with each
// live bit, and reports the final state and z count per word.
module q3c_x_stream_driver
  import q3c_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  input  logic [CW-1:0] in_len,
  input  logic          in_clr,
  output logic          x,
  output logic          x_valid,
  output logic [2:0]    y,
  output logic          z,
  output logic          done,
  output logic [CW-1:0] z_count,
  output logic [2:0]    final_state
);

  ctl_t          ctl, ctl_nxt;
  logic [CW-1:0] len_c;
  logic [CW-1:0] run_cnt;
  logic [CW-1:0] z_inc;
  logic [2:0]    y_nxt;
  logic          accept;
  logic          bit_out;
  logic          last;

  assign len_c  = (in_len > CW'(W)) ? CW'(W) : in_len;
  assign accept = in_valid & in_ready;

  q3c_piso_shifter #(.W(W), .CW(CW)) u_shifter (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept),
    .data     (in_data),
    .len      (len_c),
    .shift_en (x_valid),
    .bit_out  (bit_out),
    .last     (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) ctl <= CTL_IDLE;
    else         ctl <= ctl_nxt;
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    ctl_nxt  = ctl;
    in_ready = 1'b0;
    x_valid  = 1'b0;
    x        = 1'b0;
    done     = 1'b0;
    case (ctl)
      CTL_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) ctl_nxt = (len_c == '0) ? CTL_DONE : CTL_SHIFT;
      end
      CTL_SHIFT: begin
        x_valid = 1'b1;
        x       = bit_out;
        if (last) ctl_nxt = CTL_DONE;
      end
      CTL_DONE: begin
        done    = 1'b1;
        ctl_nxt = CTL_IDLE;
      end
      default: ctl_nxt = CTL_IDLE;
    endcase
  end

  assign y_nxt = next_state(y, bit_out);
  assign z_inc = {{(CW-1){1'b0}}, z_of(y_nxt)};
  assign z     = z_of(y);

  // Results are captured on the edge entering DONE so they are valid
  // alongside the done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      y           <= ST_A;
      run_cnt     <= '0;
      z_count     <= '0;
      final_state <= ST_A;
    end else if (accept) begin
      if (in_clr) y <= ST_A;
      run_cnt <= '0;
      if (len_c == '0) begin
        z_count     <= '0;
        final_state <= in_clr ? ST_A : y;
      end
    end else if (x_valid) begin
      y       <= y_nxt;
      run_cnt <= run_cnt + z_inc;
      if (last) begin
        z_count     <= run_cnt + z_inc;
        final_state <= y_nxt;
      end
    end
  end

endmodule

// File: tb/tb_q3c_x_stream_driver.sv
// Self-checking bench for q3c_x_stream_driver: directed words plus random
// words compared against a table-driven reference model.
module tb_q3c_x_stream_driver;

  localparam int W  = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_len;
  logic          in_clr;
  logic          x;
  logic          x_valid;
  logic [2:0]    y;
  logic          z;
  logic          done;
  logic [CW-1:0] z_count;
  logic [2:0]    final_state;

  q3c_x_stream_driver #(.W(W), .CW(CW)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_len      (in_len),
    .in_clr      (in_clr),
    .x           (x),
    .x_valid     (x_valid),
    .y           (y),
    .z           (z),
    .done        (done),
    .z_count     (z_count),
    .final_state (final_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference transition table indexed [state][x]: A,B,C,D,E.
  int nxt_tbl [0:4][0:1] = '{'{0, 1}, '{1, 4}, '{2, 1}, '{1, 2}, '{3, 4}};
  int m_y = 0;
  int last_accept = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int is_z(input int s);
    return (s == 3 || s == 4) ? 1 : 0;
  endfunction

  // Sends one word and checks every cycle of it; inputs change on negedges.
  task automatic send_word(input logic [W-1:0] data, input int len,
                           input bit clr, input bit hold);
    int budget = 50;
    int l_eff;
    int zc = 0;
    int b;
    l_eff = (len > W) ? W : len;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      check("ready_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_data  = data;
    in_len   = CW'(len);
    in_clr   = clr;
    @(posedge clk);
    @(negedge clk);
    last_accept = cyc;
    if (!hold) in_valid = 1'b0;
    if (clr) m_y = 0;
    for (int i = l_eff - 1; i >= 0; i--) begin
      b = int'(data[i]);
      check("x_valid", int'(x_valid), 1);
      check("x_bit", int'(x), b);
      check("y_pre", int'(y), m_y);
      check("z_pre", int'(z), is_z(m_y));
      check("ready_busy", int'(in_ready), 0);
      m_y = nxt_tbl[m_y][b];
      zc += is_z(m_y);
      @(negedge clk);
    end
    check("done", int'(done), 1);
    check("x_valid_done", int'(x_valid), 0);
    check("z_count", int'(z_count), zc);
    check("final_state", int'(final_state), m_y);
    check("y_done", int'(y), m_y);
    @(negedge clk);
    check("done_clear", int'(done), 0);
    check("ready_idle", int'(in_ready), 1);
  endtask

  initial begin
    int prev;
    resetn   = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    in_clr   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_y", int'(y), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_xv", int'(x_valid), 0);
    check("rst_x", int'(x), 0);
    check("rst_done", int'(done), 0);
    check("rst_zc", int'(z_count), 0);
    check("rst_fs", int'(final_state), 0);
    resetn = 1'b1;
    @(negedge clk);

    send_word(16'b1101, 4, 1'b1, 1'b0);
    check("t1_zc", int'(z_count), 2);
    check("t1_fs", int'(final_state), 2);
    send_word(16'b0000, 4, 1'b1, 1'b0);
    send_word(16'b110, 3, 1'b1, 1'b0);
    check("t3_fs", int'(final_state), 3);
    send_word(16'b1, 1, 1'b0, 1'b0);
    check("t3b_fs", int'(final_state), 2);
    send_word(16'b1, 1, 1'b1, 1'b0);
    check("t3c_fs", int'(final_state), 1);
    send_word(16'hFFFF, 0, 1'b0, 1'b0);
    check("len0_y", int'(y), 1);

    // Reset during the second bit of a 4-bit word.
    in_valid = 1'b1; in_data = 16'b1011; in_len = 5'd4; in_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check("arst_xv", int'(x_valid), 0);
    check("arst_y", int'(y), 0);
    check("arst_ready", int'(in_ready), 1);
    check("arst_done", int'(done), 0);
    m_y = 0;
    repeat (3) begin
      @(negedge clk);
      check("arst_nodone", int'(done), 0);
    end
    resetn = 1'b1;
    @(negedge clk);
    send_word(16'b0110, 4, 1'b0, 1'b0);

    // Back-to-back all-ones words with in_valid held high.
    send_word(16'hFFFF, 16, 1'b1, 1'b1);
    check("ones_zc", int'(z_count), 15);
    prev = last_accept;
    for (int k = 0; k < 3; k++) begin
      send_word(16'hFFFF, 16, 1'b0, 1'b1);
      check("b2b_gap", last_accept - prev, 18);
      prev = last_accept;
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Random words, including over-long lengths that must clamp.
    for (int k = 0; k < 40; k++) begin
      send_word(16'($urandom), $urandom_range(0, 20), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
